// File: rtl/tiger_mon_pkg.sv
// rtl/tiger_mon_pkg.sv - state encoding and default measurement window for the Tiger perf monitor
package tiger_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_HUNG = 2'd3
    } mon_state_e;

    // Same addresses as the tiger_defines start/finish markers
    localparam logic [31:0] TIGER_START_PC  = 32'h0080_0020;
    localparam logic [31:0] TIGER_FINISH_PC = 32'h0080_0028;

endpackage

// File: rtl/tiger_mon_stall_wd.sv
// rtl/tiger_mon_stall_wd.sv - one stall channel: run-length watchdog plus cumulative stall counter
module tiger_mon_stall_wd #(
    parameter int WD_W        = 10,
    parameter int STALL_LIMIT = 1000,
    parameter int STAT_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              stall,
    input  logic              wd_en,
    input  logic              count_en,
    input  logic              freeze,
    output logic              trip,
    output logic [STAT_W-1:0] total
);

    localparam logic [WD_W-1:0] LIMIT    = WD_W'(STALL_LIMIT);
    localparam logic [WD_W-1:0] LIMIT_M1 = WD_W'(STALL_LIMIT - 1);

    logic [WD_W-1:0] wd;
    logic            active;

    assign active = stall & wd_en;
    // Fires only on the increment that lands on LIMIT; a saturated watchdog stays quiet
    assign trip   = active && !freeze && (wd == LIMIT_M1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd    <= '0;
            total <= '0;
        end else if (clear) begin
            wd    <= '0;
            total <= '0;
        end else begin
            if (!freeze) begin
                if (!active)
                    wd <= '0;
                else if (wd != LIMIT)
                    wd <= wd + 1'b1;
            end
            if (count_en && stall && (total != '1))
                total <= total + 1'b1;
        end
    end

endmodule

// File: rtl/tiger_perf_monitor.sv
// rtl/tiger_perf_monitor.sv - Tiger cycle/instruction/stall monitor; TIGER_MON_SIM_CHECKS_EN adds sim-only checks
module tiger_perf_monitor
    import tiger_mon_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] START_PC     = PC_W'(TIGER_START_PC),
    parameter logic [PC_W-1:0] FINISH_PC    = PC_W'(TIGER_FINISH_PC),
    parameter int              NUM_STALL_CH = 2,
    parameter int              WD_W         = 10,
    parameter int              STALL_LIMIT  = 1000,
    parameter int              CYC_W        = 64,
    parameter int              STAT_W       = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           clear,
    input  logic [PC_W-1:0]                pc,
    input  logic                           ins_valid,
    input  logic [NUM_STALL_CH-1:0]        stall,
    input  logic [NUM_STALL_CH-1:0]        wd_en,
    output logic                           running,
    output logic                           done,
    output logic                           hung,
    output logic [NUM_STALL_CH-1:0]        hung_ch,
    output logic [CYC_W-1:0]               cycle_count,
    output logic [CYC_W-1:0]               instr_count,
    output logic [NUM_STALL_CH*STAT_W-1:0] stall_total
);

    mon_state_e              state, state_next;
    logic [NUM_STALL_CH-1:0] trip;
    logic                    in_run;
    logic                    frozen;

    assign in_run  = (state == ST_RUN);
    assign frozen  = (state == ST_HUNG);
    assign running = in_run;
    assign done    = (state == ST_DONE);
    assign hung    = frozen;

    for (genvar gi = 0; gi < NUM_STALL_CH; gi++) begin : g_ch
        tiger_mon_stall_wd #(
            .WD_W        (WD_W),
            .STALL_LIMIT (STALL_LIMIT),
            .STAT_W      (STAT_W)
        ) u_wd (
            .clk      (clk),
            .reset_n  (reset_n),
            .clear    (clear),
            .stall    (stall[gi]),
            .wd_en    (wd_en[gi]),
            .count_en (in_run),
            .freeze   (frozen),
            .trip     (trip[gi]),
            .total    (stall_total[gi*STAT_W +: STAT_W])
        );
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (|trip)
                    state_next = ST_HUNG;
                else if (pc == START_PC)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (|trip)
                    state_next = ST_HUNG;
                else if (pc == FINISH_PC)
                    state_next = ST_DONE;
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            hung_ch     <= '0;
            cycle_count <= '0;
            instr_count <= '0;
        end else if (clear) begin
            state       <= ST_IDLE;
            hung_ch     <= '0;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            state   <= state_next;
            hung_ch <= hung_ch | trip;
            // Counting keys off the current state, so the RUN->DONE/HUNG edge still counts
            if (in_run) begin
                if (cycle_count != '1)
                    cycle_count <= cycle_count + 1'b1;
                if (ins_valid && (stall == '0) && (instr_count != '1))
                    instr_count <= instr_count + 1'b1;
            end
        end
    end

`ifdef TIGER_MON_SIM_CHECKS_EN
    mon_state_e state_q;

    always @(posedge clk) begin
        state_q <= state;
        if (^pc === 1'bx) begin
            $display("PC is going undefined!");
            $finish;
        end
        if (state == ST_DONE && state_q != ST_DONE) begin
            $display("tiger_perf_monitor: cycles=%0d instrs=%0d", cycle_count, instr_count);
`ifndef PROFILER_ON
            $finish;
`endif
        end
        if (state == ST_HUNG && state_q != ST_HUNG) begin
            $display("tiger_perf_monitor: hung channels=%b", hung_ch);
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_tiger_perf_monitor.sv
// tb/tb_tiger_perf_monitor.sv - directed self-checking bench for tiger_perf_monitor
module tb_tiger_perf_monitor;

    localparam logic [31:0] START   = 32'h0080_0020;
    localparam logic [31:0] FINISH  = 32'h0080_0028;
    localparam logic [31:0] NEUTRAL = 32'h0080_0100;

    logic        clk = 1'b0;
    logic        reset_n, clear, ins_valid;
    logic [31:0] pc;
    logic [1:0]  stall, wd_en;

    logic        running, done, hung;
    logic [1:0]  hung_ch;
    logic [63:0] cycle_count, instr_count;
    logic [63:0] stall_total;

    logic        s_running, s_done, s_hung;
    logic [1:0]  s_hung_ch;
    logic [3:0]  s_cycle_count, s_instr_count;
    logic [7:0]  s_stall_total;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tiger_perf_monitor dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .pc(pc), .ins_valid(ins_valid),
        .stall(stall), .wd_en(wd_en), .running(running), .done(done), .hung(hung),
        .hung_ch(hung_ch), .cycle_count(cycle_count), .instr_count(instr_count),
        .stall_total(stall_total)
    );

    tiger_perf_monitor #(.CYC_W(4), .STAT_W(4)) dut_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .pc(pc), .ins_valid(ins_valid),
        .stall(stall), .wd_en(wd_en), .running(s_running), .done(s_done), .hung(s_hung),
        .hung_ch(s_hung_ch), .cycle_count(s_cycle_count), .instr_count(s_instr_count),
        .stall_total(s_stall_total)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        reset_n = 1'b0; clear = 1'b0; pc = NEUTRAL; ins_valid = 1'b0;
        stall = 2'b00; wd_en = 2'b00;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic run_pair(input int gap);
        pc = START;   tick(1);
        pc = NEUTRAL; tick(gap - 1);
        pc = FINISH;  tick(1);
        pc = NEUTRAL;
    endtask

    task automatic test_reset();
        reset_dut();
        n_cmp++; if ({running, done, hung, hung_ch} !== 5'b0) begin n_err++;
            $display("FAIL reset_status got=%b want=00000", {running, done, hung, hung_ch}); end
        n_cmp++; if ({cycle_count, instr_count, stall_total} !== 192'd0) begin n_err++;
            $display("FAIL reset_counters got=%0d/%0d/%0h want=0/0/0", cycle_count, instr_count, stall_total); end
        n_cmp++; if (s_cycle_count !== 4'd0) begin n_err++;
            $display("FAIL reset_sat_cycle got=%0d want=0", s_cycle_count); end
    endtask

    task automatic test_basic_run();
        reset_dut();
        ins_valid = 1'b1;
        run_pair(10);
        n_cmp++; if ({running, done, hung} !== 3'b010) begin n_err++;
            $display("FAIL basic_status got=%b want=010", {running, done, hung}); end
        n_cmp++; if (cycle_count !== 64'd10) begin n_err++;
            $display("FAIL basic_cycles got=%0d want=10", cycle_count); end
        n_cmp++; if (instr_count !== 64'd10) begin n_err++;
            $display("FAIL basic_instrs got=%0d want=10", instr_count); end
        tick(3);
        n_cmp++; if (cycle_count !== 64'd10) begin n_err++;
            $display("FAIL basic_frozen got=%0d want=10", cycle_count); end
    endtask

    task automatic test_hang_in_done();
        wd_en = 2'b01; stall = 2'b01;
        tick(999);
        n_cmp++; if (hung_ch !== 2'b00) begin n_err++;
            $display("FAIL done_hang_early got=%b want=00", hung_ch); end
        tick(1);
        n_cmp++; if ({done, hung, hung_ch} !== 4'b1001) begin n_err++;
            $display("FAIL done_hang got=%b want=1001", {done, hung, hung_ch}); end
        n_cmp++; if ({cycle_count, stall_total} !== {64'd10, 64'd0}) begin n_err++;
            $display("FAIL done_hang_counts got=%0d/%0h want=10/0", cycle_count, stall_total); end
    endtask

    task automatic test_single_hang();
        reset_dut();
        wd_en = 2'b11;
        pc = START; tick(1); pc = NEUTRAL;
        stall = 2'b10; tick(999);
        stall = 2'b00; tick(1);
        n_cmp++; if ({running, hung} !== 2'b10) begin n_err++;
            $display("FAIL wd999_status got=%b want=10", {running, hung}); end
        n_cmp++; if (stall_total[63:32] !== 32'd999) begin n_err++;
            $display("FAIL wd999_total got=%0d want=999", stall_total[63:32]); end
        stall = 2'b10; tick(999);
        n_cmp++; if (hung !== 1'b0) begin n_err++;
            $display("FAIL wd_second999 got=%b want=0", hung); end
        tick(1);
        n_cmp++; if ({hung, running, hung_ch} !== 4'b1010) begin n_err++;
            $display("FAIL wd_trip got=%b want=1010", {hung, running, hung_ch}); end
        tick(5);
        n_cmp++; if (stall_total !== {32'd1999, 32'd0}) begin n_err++;
            $display("FAIL wd_frozen_total got=%0h want=%0h", stall_total, {32'd1999, 32'd0}); end
        n_cmp++; if (cycle_count !== 64'd2000) begin n_err++;
            $display("FAIL wd_frozen_cycles got=%0d want=2000", cycle_count); end
    endtask

    task automatic test_dual_hang();
        reset_dut();
        wd_en = 2'b11;
        pc = START; tick(1); pc = NEUTRAL;
        stall = 2'b11; tick(999);
        n_cmp++; if (hung_ch !== 2'b00) begin n_err++;
            $display("FAIL dual_early got=%b want=00", hung_ch); end
        tick(1);
        n_cmp++; if ({hung, hung_ch} !== 3'b111) begin n_err++;
            $display("FAIL dual_trip got=%b want=111", {hung, hung_ch}); end
        reset_dut();
        wd_en = 2'b01;
        pc = START; tick(1); pc = NEUTRAL;
        stall = 2'b11; tick(1000);
        n_cmp++; if ({hung, hung_ch} !== 3'b101) begin n_err++;
            $display("FAIL masked_trip got=%b want=101", {hung, hung_ch}); end
    endtask

    task automatic test_finish_in_idle();
        reset_dut();
        pc = FINISH; tick(3); pc = NEUTRAL;
        n_cmp++; if ({running, done, cycle_count} !== 66'd0) begin n_err++;
            $display("FAIL idle_finish got=%b%b/%0d want=00/0", running, done, cycle_count); end
        run_pair(5);
        n_cmp++; if ({done, cycle_count} !== {1'b1, 64'd5}) begin n_err++;
            $display("FAIL gap5 got=%b/%0d want=1/5", done, cycle_count); end
    endtask

    task automatic test_restart();
        reset_dut();
        pc = START; tick(1); pc = NEUTRAL; tick(37);
        n_cmp++; if (cycle_count !== 64'd37) begin n_err++;
            $display("FAIL mid_run got=%0d want=37", cycle_count); end
        reset_n = 1'b0; #1;
        n_cmp++; if ({running, cycle_count} !== 65'd0) begin n_err++;
            $display("FAIL async_reset got=%b/%0d want=0/0", running, cycle_count); end
        tick(2); reset_n = 1'b1; tick(1);
        run_pair(3);
        n_cmp++; if ({done, cycle_count} !== {1'b1, 64'd3}) begin n_err++;
            $display("FAIL after_reset got=%b/%0d want=1/3", done, cycle_count); end
        clear = 1'b1; tick(1); clear = 1'b0;
        pc = START; tick(1); pc = NEUTRAL; tick(37);
        clear = 1'b1; tick(1); clear = 1'b0;
        n_cmp++; if ({running, cycle_count} !== 65'd0) begin n_err++;
            $display("FAIL sync_clear got=%b/%0d want=0/0", running, cycle_count); end
        run_pair(3);
        n_cmp++; if ({done, cycle_count} !== {1'b1, 64'd3}) begin n_err++;
            $display("FAIL after_clear got=%b/%0d want=1/3", done, cycle_count); end
    endtask

    task automatic test_saturation();
        reset_dut();
        ins_valid = 1'b1; stall = 2'b01;
        pc = START; tick(1); pc = NEUTRAL; tick(20);
        n_cmp++; if ({s_cycle_count, s_stall_total[3:0]} !== 8'hFF) begin n_err++;
            $display("FAIL sat_cycle_stall got=%0d/%0d want=15/15", s_cycle_count, s_stall_total[3:0]); end
        n_cmp++; if ({cycle_count, stall_total[31:0]} !== {64'd20, 32'd20}) begin n_err++;
            $display("FAIL wide_cycle_stall got=%0d/%0d want=20/20", cycle_count, stall_total[31:0]); end
        n_cmp++; if (instr_count !== 64'd0) begin n_err++;
            $display("FAIL stall_blocks_instr got=%0d want=0", instr_count); end
        stall = 2'b00; tick(20);
        n_cmp++; if ({s_instr_count, s_running} !== 5'b11111) begin n_err++;
            $display("FAIL sat_instr got=%0d/%b want=15/1", s_instr_count, s_running); end
        n_cmp++; if (instr_count !== 64'd20) begin n_err++;
            $display("FAIL wide_instr got=%0d want=20", instr_count); end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_hang_in_done();
        test_single_hang();
        test_dual_hang();
        test_finish_in_idle();
        test_restart();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
